// File: rtl/dl_router.sv
// dl_router: demultiplexes the HPS ioctl download stream into NUM_REGIONS word-wide write ports
// and holds the core in reset while a boot image loads. Optional byte checksum: DL_ROUTER_CHECKSUM_EN.
module dl_router #(
  parameter int NUM_REGIONS = 4,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 17,
  parameter int RESET_HOLD  = 16,
  parameter logic [NUM_REGIONS-1:0] BOOT_MASK = 'b0011
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   dn_download,
  input  logic                   dn_wr,
  input  logic [24:0]            dn_addr,
  input  logic [7:0]             dn_data,
  input  logic [7:0]             dn_index,
  output logic [NUM_REGIONS-1:0] wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   core_reset,
  output logic                   busy,
  output logic [NUM_REGIONS-1:0] done,
  output logic                   overflow,
  output logic [15:0]            checksum
);

  localparam int BYTES = DATA_W / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int LW    = (LB == 0) ? 1 : LB;
  localparam int HW    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
  localparam logic [8:0]    NR        = 9'(NUM_REGIONS);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, HOLD} state_t;

  state_t                 state;
  logic                   dl_q;
  logic [7:0]             idx;
  logic [DATA_W-1:0]      lane_buf;
  logic                   pending;
  logic [ADDR_W-1:0]      last_addr;
  logic [HW-1:0]          hold_cnt;

  logic                   dl_rise;
  logic                   start;
  logic                   idx_valid;
  logic [NUM_REGIONS-1:0] region_hot;
  logic                   is_boot;
  logic [LW-1:0]          lane;
  logic                   lane_last;
  logic [ADDR_W-1:0]      word_addr;
  logic                   addr_oob;
  logic                   accept;
  logic [DATA_W-1:0]      merged;
  logic                   pend_next;
  logic [DATA_W-1:0]      flush_word;
  logic [ADDR_W-1:0]      flush_addr;

  assign dl_rise    = dn_download & ~dl_q;
  assign start      = dl_rise & (state != LOAD);
  assign idx_valid  = {1'b0, idx} < NR;
  assign region_hot = idx_valid ? (NUM_REGIONS'(1) << idx) : '0;
  assign is_boot    = |(BOOT_MASK & region_hot);

  assign lane       = (LB == 0) ? '0 : dn_addr[LW-1:0];
  assign lane_last  = (lane == LW'(BYTES - 1));
  assign word_addr  = dn_addr[ADDR_W+LB-1:LB];
  assign addr_oob   = (dn_addr >> (ADDR_W + LB)) != 25'd0;
  assign accept     = (state == LOAD) & dn_wr & idx_valid & ~addr_oob;

  always_comb begin
    merged = lane_buf;
    merged[int'(lane)*8 +: 8] = dn_data;
  end

  // A byte arriving together with the falling download edge is merged before the flush decision.
  assign pend_next  = accept ? ~lane_last : pending;
  assign flush_word = (accept & ~lane_last) ? merged : lane_buf;
  assign flush_addr = accept ? word_addr : last_addr;

  assign busy       = (state != IDLE);
  assign core_reset = reset | (busy & is_boot);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      dl_q      <= 1'b0;
      idx       <= '0;
      lane_buf  <= '0;
      pending   <= 1'b0;
      last_addr <= '0;
      hold_cnt  <= '0;
      wr_en     <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= '0;
      overflow  <= 1'b0;
    end else begin
      dl_q  <= dn_download;
      wr_en <= '0;
      done  <= '0;

      case (state)
        IDLE: ;

        LOAD: begin
          if (dn_wr) begin
            if (addr_oob) overflow <= 1'b1;
            if (accept) begin
              last_addr <= word_addr;
              if (lane_last) begin
                wr_en    <= region_hot;
                wr_addr  <= word_addr;
                wr_data  <= merged;
                lane_buf <= '0;
                pending  <= 1'b0;
              end else begin
                lane_buf <= merged;
                pending  <= 1'b1;
              end
            end
          end
          if (!dn_download) begin
            if (pend_next) begin
              state    <= FLUSH;
              wr_en    <= region_hot;
              wr_addr  <= flush_addr;
              wr_data  <= flush_word;
              lane_buf <= '0;
              pending  <= 1'b0;
            end else begin
              state    <= HOLD;
            end
            hold_cnt <= '0;
          end
        end

        FLUSH: begin
          if (start) begin
            done <= region_hot;
          end else begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end

        HOLD: begin
          if (start) begin
            done <= region_hot;
          end else if (hold_cnt == HOLD_LAST) begin
            done  <= region_hot;
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase

      // A new download abandons whatever tail is in progress and re-latches the index.
      if (start) begin
        state    <= LOAD;
        idx      <= dn_index;
        overflow <= ({1'b0, dn_index} >= NR);
        lane_buf <= '0;
        pending  <= 1'b0;
      end
    end
  end

`ifdef DL_ROUTER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk_sys) begin
    if (reset || start) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + {8'h00, dn_data};
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_dl_router.sv
// tb_dl_router: directed bench driving three dl_router builds (DATA_W 8/16/32) from one download
// stream; expected writes, reset timing and done pulses are hand-computed below.
module tb_dl_router;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  en;
    logic [16:0] addr;
    logic [31:0] data;
  } wr_t;

`ifdef DL_ROUTER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        dn_download;
  logic        dn_wr;
  logic [24:0] dn_addr;
  logic [7:0]  dn_data;
  logic [7:0]  dn_index;

  logic [3:0]  wr_en8, wr_en16, wr_en32;
  logic [16:0] wr_addr8, wr_addr16, wr_addr32;
  logic [7:0]  wr_data8;
  logic [15:0] wr_data16;
  logic [31:0] wr_data32;
  logic        core_reset8, core_reset16, core_reset32;
  logic        busy8, busy16, busy32;
  logic [3:0]  done8, done16, done32;
  logic        overflow8, overflow16, overflow32;
  logic [15:0] checksum8, checksum16, checksum32;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  wr_t  q8[$], q16[$], q32[$];
  wr_t  e8[$], e16[$], e32[$];
  int   done_cnt8 = 0, done_cnt16 = 0, done_cnt32 = 0;
  logic [3:0] done_last8 = '0, done_last16 = '0, done_last32 = '0;

  dl_router #(.DATA_W(8)) u_dut8 (
    .clk_sys(clk), .reset(reset), .dn_download(dn_download), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_index(dn_index),
    .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8), .core_reset(core_reset8),
    .busy(busy8), .done(done8), .overflow(overflow8), .checksum(checksum8));

  dl_router #(.DATA_W(16)) u_dut16 (
    .clk_sys(clk), .reset(reset), .dn_download(dn_download), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_index(dn_index),
    .wr_en(wr_en16), .wr_addr(wr_addr16), .wr_data(wr_data16), .core_reset(core_reset16),
    .busy(busy16), .done(done16), .overflow(overflow16), .checksum(checksum16));

  dl_router #(.DATA_W(32)) u_dut32 (
    .clk_sys(clk), .reset(reset), .dn_download(dn_download), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_index(dn_index),
    .wr_en(wr_en32), .wr_addr(wr_addr32), .wr_data(wr_data32), .core_reset(core_reset32),
    .busy(busy32), .done(done32), .overflow(overflow32), .checksum(checksum32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic wr_t mk(input int c, input logic [3:0] e, input logic [16:0] a,
                             input logic [31:0] d);
    wr_t w;
    w.cyc  = 32'(c);
    w.en   = e;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, then sample #1 after the edge and log writes and done pulses.
  task automatic applyStimulus(input logic dl, input logic wr, input logic [24:0] a,
                               input logic [7:0] d);
    dn_download = dl;
    dn_wr       = wr;
    dn_addr     = a;
    dn_data     = d;
    @(posedge clk);
    #1;
    cyc++;
    if (|wr_en8)  q8.push_back(mk(cyc, wr_en8, wr_addr8, 32'(wr_data8)));
    if (|wr_en16) q16.push_back(mk(cyc, wr_en16, wr_addr16, 32'(wr_data16)));
    if (|wr_en32) q32.push_back(mk(cyc, wr_en32, wr_addr32, wr_data32));
    if (|done8)  begin done_cnt8++;  done_last8  = done8;  end
    if (|done16) begin done_cnt16++; done_last16 = done16; end
    if (|done32) begin done_cnt32++; done_last32 = done32; end
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (!busy8 && !busy16 && !busy32) break;
      applyStimulus(1'b0, 1'b0, '0, '0);
    end
    checkOutput({tag, "_idle"}, {busy8, busy16, busy32}, 0);
  endtask

  task automatic cmpq(input string tag, input wr_t got[$], input wr_t exp[$]);
    checkOutput({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checkOutput($sformatf("%s_w%0d", tag, i), {got[i].en, got[i].addr, got[i].data},
                  {exp[i].en, exp[i].addr, exp[i].data});
      checkOutput($sformatf("%s_cyc%0d", tag, i), got[i].cyc, exp[i].cyc);
    end
  endtask

  task automatic cmpAll(input string tag);
    cmpq({tag, "_d8"}, q8, e8);
    cmpq({tag, "_d16"}, q16, e16);
    cmpq({tag, "_d32"}, q32, e32);
    q8.delete(); q16.delete(); q32.delete();
    e8.delete(); e16.delete(); e32.delete();
  endtask

  initial begin
    int c[8];
    int f;
    int f2;
    int dc8, dc16, dc32;

    reset = 1'b1;
    dn_index = '0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("rst_wr_en", wr_en16, 0);
    checkOutput("rst_wr_addr", wr_addr16, 0);
    checkOutput("rst_wr_data", wr_data16, 0);
    checkOutput("rst_done", done16, 0);
    checkOutput("rst_overflow", overflow16, 0);
    checkOutput("rst_checksum", checksum16, 0);
    checkOutput("rst_busy", busy16, 0);
    checkOutput("rst_core_reset", core_reset16, 1);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("rst_release_core_reset", core_reset16, 0);

    // Test 1: index 1, four bytes 0x11..0x44, clean drop.
    $display("[TB] test 1: index 1, four bytes");
    dn_index = 8'd1;
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t1_busy", busy16, 1);
    checkOutput("t1_core_reset_rise", core_reset16, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 25'(i), 8'(8'h11 * (i + 1)));
      c[i] = cyc;
    end
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("t1_hold_entry_reset", core_reset16, 1);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(1'b0, 1'b0, '0, '0);
      checkOutput($sformatf("t1_hold_reset_%0d", k), {core_reset16, done16}, {1'b1, 4'b0000});
    end
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("t1_reset_fall", core_reset16, 0);
    checkOutput("t1_done_pulse", done16, 4'b0010);
    checkOutput("t1_busy_end", busy16, 0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("t1_done_single", done16, 0);
    checkOutput("t1_wr_data_held", wr_data16, 16'h4433);
    checkOutput("t1_wr_addr_held", wr_addr16, 1);
    checkOutput("t1_checksum16", checksum16, CK ? 16'h00AA : 16'h0000);
    checkOutput("t1_checksum32", checksum32, CK ? 16'h00AA : 16'h0000);
    e16.push_back(mk(c[1], 4'b0010, 17'd0, 32'h2211));
    e16.push_back(mk(c[3], 4'b0010, 17'd1, 32'h4433));
    e32.push_back(mk(c[3], 4'b0010, 17'd0, 32'h44332211));
    for (int i = 0; i < 4; i++) e8.push_back(mk(c[i], 4'b0010, 17'(i), 32'(8'h11 * (i + 1))));
    cmpAll("t1");

    // Test 2: index 0, five bytes, last byte arrives with the falling edge.
    $display("[TB] test 2: index 0, five bytes with partial flush");
    dc32 = done_cnt32;
    dn_index = 8'd0;
    applyStimulus(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i != 4, 1'b1, 25'(i), 8'(i + 1));
      c[i] = cyc;
    end
    dn_wr = 1'b0;
    waitIdle("t2");
    e32.push_back(mk(c[3], 4'b0001, 17'd0, 32'h04030201));
    e32.push_back(mk(c[4], 4'b0001, 17'd1, 32'h00000005));
    e16.push_back(mk(c[1], 4'b0001, 17'd0, 32'h0201));
    e16.push_back(mk(c[3], 4'b0001, 17'd1, 32'h0403));
    e16.push_back(mk(c[4], 4'b0001, 17'd2, 32'h0005));
    for (int i = 0; i < 5; i++) e8.push_back(mk(c[i], 4'b0001, 17'(i), 32'(i + 1)));
    cmpAll("t2");
    checkOutput("t2_done_count32", done_cnt32 - dc32, 1);
    checkOutput("t2_done_last32", done_last32, 4'b0001);
    checkOutput("t2_checksum32", checksum32, CK ? 16'h000F : 16'h0000);

    // Test 3: index 2 is not a boot image.
    $display("[TB] test 3: non-boot index 2");
    dn_index = 8'd2;
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t3_start", {busy16, core_reset16}, 2'b10);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 25'(i), 8'(8'hA0 + i));
      c[i] = cyc;
      checkOutput($sformatf("t3_load_%0d", i), {busy16, core_reset16}, 2'b10);
    end
    applyStimulus(1'b0, 1'b0, '0, '0);
    f = cyc;
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(1'b0, 1'b0, '0, '0);
      checkOutput($sformatf("t3_hold_%0d", k), {busy16, core_reset16}, 2'b10);
    end
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("t3_end", {busy16, core_reset16, done16}, {2'b00, 4'b0100});
    waitIdle("t3");
    e16.push_back(mk(c[1], 4'b0100, 17'd0, 32'hA1A0));
    e32.push_back(mk(f, 4'b0100, 17'd0, 32'h0000A1A0));
    e8.push_back(mk(c[0], 4'b0100, 17'd0, 32'hA0));
    e8.push_back(mk(c[1], 4'b0100, 17'd1, 32'hA1));
    cmpAll("t3");

    // Test 4a: invalid index 7 drops everything.
    $display("[TB] test 4: invalid index and out-of-range address");
    dc8 = done_cnt8; dc16 = done_cnt16; dc32 = done_cnt32;
    dn_index = 8'd7;
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t4a_overflow_entry", overflow8, 1);
    checkOutput("t4a_core_reset", core_reset8, 0);
    checkOutput("t4a_busy", busy8, 1);
    applyStimulus(1'b1, 1'b1, 25'd0, 8'h12);
    applyStimulus(1'b1, 1'b1, 25'd1, 8'h34);
    applyStimulus(1'b0, 1'b0, '0, '0);
    waitIdle("t4a");
    cmpAll("t4a");
    checkOutput("t4a_no_done", {done_cnt8 - dc8, done_cnt16 - dc16, done_cnt32 - dc32}, 0);
    checkOutput("t4a_overflow_sticky", {overflow8, overflow32}, 2'b11);
    checkOutput("t4a_checksum", checksum16, 0);

    // Test 4b: byte address just past the 8-bit region's range.
    dn_index = 8'd3;
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t4b_overflow_cleared", overflow8, 0);
    applyStimulus(1'b1, 1'b1, 25'h20000, 8'h5A);
    checkOutput("t4b_overflow_set", overflow8, 1);
    checkOutput("t4b_no_wr_en", wr_en8, 0);
    checkOutput("t4b_overflow16_clear", overflow16, 0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    f = cyc;
    waitIdle("t4b");
    e16.push_back(mk(f, 4'b1000, 17'h10000, 32'h5A));
    e32.push_back(mk(f, 4'b1000, 17'h08000, 32'h5A));
    cmpAll("t4b");
    checkOutput("t4b_checksum8", checksum8, 0);
    checkOutput("t4b_checksum16", checksum16, CK ? 16'h005A : 16'h0000);

    // Test 5: reset in the middle of a load.
    $display("[TB] test 5: reset mid-load");
    dc32 = done_cnt32;
    dn_index = 8'd0;
    applyStimulus(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 25'(i), 8'(8'h10 * (i + 1)));
      c[i] = cyc;
    end
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("t5_busy", busy32, 0);
    checkOutput("t5_done", done32, 0);
    checkOutput("t5_wr_en", wr_en32, 0);
    checkOutput("t5_core_reset", core_reset32, 1);
    checkOutput("t5_wr_data", wr_data32, 0);
    checkOutput("t5_checksum", checksum32, 0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, '0, '0);
      checkOutput($sformatf("t5_after_%0d", k), {busy32, core_reset32, wr_en32}, 0);
    end
    e16.push_back(mk(c[1], 4'b0001, 17'd0, 32'h2010));
    for (int i = 0; i < 3; i++) e8.push_back(mk(c[i], 4'b0001, 17'(i), 32'(8'h10 * (i + 1))));
    cmpAll("t5");
    checkOutput("t5_no_done", done_cnt32 - dc32, 0);

    // Test 6: a new download starts five cycles into the hold tail.
    $display("[TB] test 6: restart during hold");
    dn_index = 8'd1;
    applyStimulus(1'b1, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b1, 25'd0, 8'h01);
    c[0] = cyc;
    applyStimulus(1'b1, 1'b1, 25'd1, 8'h02);
    c[1] = cyc;
    applyStimulus(1'b0, 1'b0, '0, '0);
    f = cyc;
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, '0, '0);
    dn_index = 8'd2;
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t6_done_old", done16, 4'b0010);
    checkOutput("t6_done_old8", done8, 4'b0010);
    checkOutput("t6_new_load", {busy16, core_reset16}, 2'b10);
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t6_done_single", done16, 0);
    applyStimulus(1'b1, 1'b1, 25'd0, 8'h77);
    c[2] = cyc;
    applyStimulus(1'b0, 1'b0, '0, '0);
    f2 = cyc;
    waitIdle("t6");
    checkOutput("t6_done_new", done_last16, 4'b0100);
    e16.push_back(mk(c[1], 4'b0010, 17'd0, 32'h0201));
    e16.push_back(mk(f2, 4'b0100, 17'd0, 32'h0077));
    e32.push_back(mk(f, 4'b0010, 17'd0, 32'h0201));
    e32.push_back(mk(f2, 4'b0100, 17'd0, 32'h0077));
    e8.push_back(mk(c[0], 4'b0010, 17'd0, 32'h01));
    e8.push_back(mk(c[1], 4'b0010, 17'd1, 32'h02));
    e8.push_back(mk(c[2], 4'b0100, 17'd0, 32'h77));
    cmpAll("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
